// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Port ids index the per-port ack/rdata vectors in the top level.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StXferLo = 2'd1,
      StXferHi = 2'd2
   } state_e;

   localparam int unsigned NUM_PORTS = 2;
   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of mem_port_arbiter.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface mem_port_arbiter_if #(
   parameter int unsigned word_size = 8,
   parameter int unsigned len_log_2 = 16
);
   logic                   p0_req, p0_we, p0_wide, p0_ack;
   logic [len_log_2-1:0]   p0_addr;
   logic [2*word_size-1:0] p0_wdata, p0_rdata;
   logic                   p1_req, p1_we, p1_wide, p1_ack;
   logic [len_log_2-1:0]   p1_addr;
   logic [2*word_size-1:0] p1_wdata, p1_rdata;
   logic [len_log_2-1:0]   mem_addr;
   logic [word_size-1:0]   mem_wdata, mem_rdata;
   logic                   mem_we;

   modport slave (
      input  p0_req, p0_we, p0_wide, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_wide, p1_addr, p1_wdata,
      input  mem_rdata,
      output p0_rdata, p0_ack, p1_rdata, p1_ack,
      output mem_addr, mem_wdata, mem_we
   );

   modport master (
      output p0_req, p0_we, p0_wide, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_wide, p1_addr, p1_wdata,
      output mem_rdata,
      input  p0_rdata, p0_ack, p1_rdata, p1_ack,
      input  mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-input round-robin picker.
// On a tie the port that did not win last time is chosen.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
   input  logic                 last_grant,
   output logic                 grant_valid,
   output logic                 grant_id
);
   assign grant_valid = |req;

   always_comb begin
      grant_id = req[PORT_DATA];
      if (&req) grant_id = ~last_grant;
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch/data ports onto one byte-wide memory; 16-bit transfers
// are sequenced as two byte accesses (low byte first, address wraps).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned word_size = 8,
   parameter int unsigned len_log_2 = 16
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);
   localparam int unsigned DataWidth = 2 * word_size;

   state_e                              state_q, state_d;
   logic [NUM_PORTS-1:0]                req_raw, req_masked, ack_q;
   logic [NUM_PORTS-1:0][DataWidth-1:0] rdata_q;
   logic                                last_grant_q, grant_valid, grant_id;
   logic                                id_q, we_q, wide_q;
   logic [len_log_2-1:0]                addr_q, sel_addr, mem_addr;
   logic [DataWidth-1:0]                wdata_q, sel_wdata;
   logic [word_size-1:0]                rdata_lo_q, mem_wdata;
   logic                                sel_we, sel_wide, mem_we_raw, take_grant, xfer_done;

   // A port is not eligible in its own ack cycle; re-requests wait one cycle.
   assign req_raw    = {bus.p1_req, bus.p0_req};
   assign req_masked = req_raw & ~ack_q;

   rr_arb2 u_rr_arb2 (
      .req         (req_masked),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign sel_we    = grant_id ? bus.p1_we    : bus.p0_we;
   assign sel_wide  = grant_id ? bus.p1_wide  : bus.p0_wide;
   assign sel_addr  = grant_id ? bus.p1_addr  : bus.p0_addr;
   assign sel_wdata = grant_id ? bus.p1_wdata : bus.p0_wdata;

   always_ff @(posedge clk) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      take_grant = 1'b0;
      xfer_done  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_we_raw = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (grant_valid) begin
               take_grant = 1'b1;
               state_d    = StXferLo;
            end
         end
         StXferLo: begin
            mem_addr   = addr_q;
            mem_wdata  = wdata_q[word_size-1:0];
            mem_we_raw = we_q;
            xfer_done  = ~wide_q;
            state_d    = wide_q ? StXferHi : StIdle;
         end
         StXferHi: begin
            mem_addr   = addr_q + len_log_2'(1);
            mem_wdata  = wdata_q[DataWidth-1:word_size];
            mem_we_raw = we_q;
            xfer_done  = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Gating with reset keeps a reset edge from committing a write.
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   assign bus.mem_we    = mem_we_raw & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         ack_q        <= '0;
         rdata_q      <= '0;
         rdata_lo_q   <= '0;
         id_q         <= 1'b0;
         we_q         <= 1'b0;
         wide_q       <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         ack_q <= '0;
         if (take_grant) begin
            last_grant_q <= grant_id;
            id_q         <= grant_id;
            we_q         <= sel_we;
            wide_q       <= sel_wide;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
         end
         if (state_q == StXferLo && !we_q) rdata_lo_q <= bus.mem_rdata;
         if (xfer_done) begin
            ack_q[id_q] <= 1'b1;
            if (!we_q) begin
               rdata_q[id_q] <= (state_q == StXferHi) ? {bus.mem_rdata, rdata_lo_q}
                                                      : {{word_size{1'b0}}, bus.mem_rdata};
            end
         end
      end
   end

   assign bus.p0_ack   = ack_q[PORT_FETCH];
   assign bus.p1_ack   = ack_q[PORT_DATA];
   assign bus.p0_rdata = rdata_q[PORT_FETCH];
   assign bus.p1_rdata = rdata_q[PORT_DATA];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural byte memory plus a transaction-level
// model that orders grants round-robin and replays them on a reference array.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic init_mem = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.word_size(8), .len_log_2(16)) bus ();

   mem_port_arbiter #(.word_size(8), .len_log_2(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [1:0]  req = 2'b00, we = 2'b00, wide = 2'b00;
   logic [15:0] addr [2];
   logic [15:0] wdata [2];
   logic [1:0]  ack;
   logic [15:0] rdata [2];

   assign bus.p0_req = req[0];  assign bus.p1_req = req[1];
   assign bus.p0_we = we[0];    assign bus.p1_we = we[1];
   assign bus.p0_wide = wide[0]; assign bus.p1_wide = wide[1];
   assign bus.p0_addr = addr[0]; assign bus.p1_addr = addr[1];
   assign bus.p0_wdata = wdata[0]; assign bus.p1_wdata = wdata[1];
   assign ack = {bus.p1_ack, bus.p0_ack};
   assign rdata[0] = bus.p0_rdata;
   assign rdata[1] = bus.p1_rdata;

   // Main memory stand-in: combinational read, write on the clock edge.
   logic [7:0] mem [65536];
   logic [7:0] ref_mem [65536];
   assign bus.mem_rdata = mem[bus.mem_addr];
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 65536; i++) mem[i] <= 8'(i * 7 + 3);
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   int n_vec = 0;
   int n_err = 0;

   // Model state
   logic        model_last;
   logic [15:0] exp_port [2];
   int          exp_n, exp_lat0;
   int          exp_ord [2];
   logic [15:0] exp_rd [2];

   // Observed transaction results
   int          nd, we_cyc;
   int          ord [2];
   int          lat [2];
   logic [15:0] got_rd [2];

   task automatic model_pair(input logic [1:0] act);
      int seq [2];
      int p;
      logic [15:0] a, a1;
      exp_n = 0;
      if (act == 2'b11) begin
         seq[0] = model_last ? 0 : 1;
         seq[1] = 1 - seq[0];
         exp_n = 2;
      end else begin
         seq[0] = act[1] ? 1 : 0;
         exp_n = 1;
      end
      for (int i = 0; i < exp_n; i++) begin
         p = seq[i];
         a = addr[p];
         a1 = a + 16'd1;
         if (we[p]) begin
            ref_mem[a] = wdata[p][7:0];
            if (wide[p]) ref_mem[a1] = wdata[p][15:8];
         end else begin
            exp_port[p] = wide[p] ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
         end
         exp_ord[i] = p;
         exp_rd[i] = exp_port[p];
         if (i == 0) exp_lat0 = wide[p] ? 3 : 2;
         model_last = p[0];
      end
   endtask

   // Starts at posedge+1 with the DUT idle; ends at posedge+1 after the last ack.
   task automatic run_pair(input logic [1:0] act);
      logic [1:0] pending;
      int cyc;
      pending = act;
      req = act;
      nd = 0;
      we_cyc = 0;
      cyc = 0;
      while (pending != 2'b00 && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (bus.mem_we) we_cyc++;
         for (int p = 0; p < 2; p++) begin
            if (ack[p] && pending[p]) begin
               ord[nd] = p;
               lat[nd] = cyc - 1;
               got_rd[nd] = rdata[p];
               nd++;
               pending[p] = 1'b0;
               req[p] = 1'b0;
            end
         end
      end
      if (pending != 2'b00) begin
         n_vec++; n_err++;
         $display("FAIL ack_timeout: pending %b want 00", pending);
         req = 2'b00;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req = 2'b00;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_last = 1'b1;
      exp_port[0] = 16'h0; exp_port[1] = 16'h0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 7 + 3);
      addr[0] = 16'h0; addr[1] = 16'h0; wdata[0] = 16'h0; wdata[1] = 16'h0;
      reset = 1'b1;
      init_mem = 1'b1;
      @(posedge clk); #1 init_mem = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (ack !== 2'b00) begin n_err++; $display("FAIL reset_ack: got %b want 00", ack); end
      n_vec++;
      if (rdata[0] !== 16'h0 || rdata[1] !== 16'h0) begin
         n_err++; $display("FAIL reset_rdata: got %h/%h want 0000/0000", rdata[0], rdata[1]);
      end
      n_vec++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 25'h0) begin
         n_err++;
         $display("FAIL reset_mem_if: got we=%b addr=%h wdata=%h want 0/0000/00",
                  bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      @(posedge clk); #1 reset = 1'b0;
      model_last = 1'b1;
      exp_port[0] = 16'h0; exp_port[1] = 16'h0;
   endtask

   task automatic test_narrow_p1();
      we = 2'b10; wide = 2'b00; addr[1] = 16'h0010; wdata[1] = 16'h00A5;
      model_pair(2'b10); run_pair(2'b10);
      n_vec++;
      if (lat[0] !== 2) begin n_err++; $display("FAIL narrow_wr_lat: got %0d want 2", lat[0]); end
      n_vec++;
      if (we_cyc !== 1) begin n_err++; $display("FAIL narrow_wr_we_cycles: got %0d want 1", we_cyc); end
      n_vec++;
      if (mem[16'h0010] !== 8'hA5) begin
         n_err++; $display("FAIL narrow_wr_byte: got %h want a5", mem[16'h0010]);
      end
      we = 2'b00;
      model_pair(2'b10); run_pair(2'b10);
      n_vec++;
      if (got_rd[0] !== 16'h00A5 || lat[0] !== 2) begin
         n_err++; $display("FAIL narrow_rd: got %h lat %0d want 00a5 lat 2", got_rd[0], lat[0]);
      end
   endtask

   task automatic test_wide_wrap();
      we = 2'b01; wide = 2'b01; addr[0] = 16'hFFFF; wdata[0] = 16'h1234;
      model_pair(2'b01); run_pair(2'b01);
      n_vec++;
      if (lat[0] !== 3 || we_cyc !== 2) begin
         n_err++; $display("FAIL wide_wr_timing: got lat %0d we %0d want 3/2", lat[0], we_cyc);
      end
      n_vec++;
      if (mem[16'hFFFF] !== 8'h34 || mem[16'h0000] !== 8'h12) begin
         n_err++;
         $display("FAIL wide_wr_wrap: got %h,%h want 34,12", mem[16'hFFFF], mem[16'h0000]);
      end
      we = 2'b00;
      model_pair(2'b01); run_pair(2'b01);
      n_vec++;
      if (got_rd[0] !== 16'h1234 || lat[0] !== 3) begin
         n_err++; $display("FAIL wide_rd_wrap: got %h lat %0d want 1234 lat 3", got_rd[0], lat[0]);
      end
      wide = 2'b00;
   endtask

   task automatic test_contention();
      int n, cyc, prev_cyc;
      logic [15:0] exp;
      do_reset();
      we = 2'b00; wide = 2'b00;
      addr[0] = 16'(16'h0040 + $urandom_range(0, 15));
      addr[1] = 16'(16'h0050 + $urandom_range(0, 15));
      req = 2'b11;
      n = 0; cyc = 0; prev_cyc = 0;
      while (n < 6 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (ack != 2'b00) begin
            n_vec++;
            if (ack !== ((n % 2 == 0) ? 2'b01 : 2'b10)) begin
               n_err++; $display("FAIL contention_order: ack %0d got %b", n, ack);
            end
            n_vec++;
            if (cyc - prev_cyc !== ((n == 0) ? 3 : 2)) begin
               n_err++;
               $display("FAIL contention_spacing: got %0d want %0d", cyc - prev_cyc,
                        (n == 0) ? 3 : 2);
            end
            exp = {8'h00, ref_mem[addr[n % 2]]};
            n_vec++;
            if (rdata[n % 2] !== exp) begin
               n_err++; $display("FAIL contention_rdata: got %h want %h", rdata[n % 2], exp);
            end
            prev_cyc = cyc;
            n++;
            if (n == 6) req = 2'b00;
         end
      end
      if (n < 6) begin
         n_vec++; n_err++; $display("FAIL contention_timeout: got %0d acks want 6", n);
      end
      req = 2'b00;
      exp_port[0] = {8'h00, ref_mem[addr[0]]};
      exp_port[1] = {8'h00, ref_mem[addr[1]]};
      model_last = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int n, cyc, last_ack;
      we = 2'b10; wide = 2'b00;
      addr[1] = 16'(16'h0060 + $urandom_range(0, 15));
      wdata[1] = 16'($urandom);
      req = 2'b10;
      n = 0; cyc = 0; last_ack = -10;
      while (n < 3 && cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (cyc == last_ack + 1) begin
            n_vec++;
            if (bus.mem_we !== 1'b0) begin
               n_err++; $display("FAIL b2b_bubble_we: got %b want 0", bus.mem_we);
            end
         end
         if (ack[1]) begin
            n_vec++;
            if (n > 0 && cyc - last_ack !== 3) begin
               n_err++; $display("FAIL b2b_spacing: got %0d want 3", cyc - last_ack);
            end
            last_ack = cyc;
            n++;
            if (n == 3) req = 2'b00;
         end
      end
      if (n < 3) begin
         n_vec++; n_err++; $display("FAIL b2b_timeout: got %0d acks want 3", n);
      end
      req = 2'b00;
      ref_mem[addr[1]] = wdata[1][7:0];
      model_last = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      we = 2'b10; wide = 2'b00; addr[1] = 16'h0101; wdata[1] = 16'h005A;
      model_pair(2'b10); run_pair(2'b10);
      we = 2'b01; wide = 2'b01; addr[0] = 16'h0100; wdata[0] = 16'hBEEF;
      req = 2'b01;
      repeat (3) @(negedge clk);
      n_vec++;
      if (bus.mem_addr !== 16'h0101) begin
         n_err++; $display("FAIL mid_hi_addr: got %h want 0101", bus.mem_addr);
      end
      reset = 1'b1;
      #1;
      n_vec++;
      if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL mid_we_gate: got %b want 0", bus.mem_we); end
      @(posedge clk); #1 req = 2'b00;
      @(negedge clk);
      n_vec++;
      if (ack !== 2'b00 || rdata[0] !== 16'h0 || rdata[1] !== 16'h0) begin
         n_err++; $display("FAIL mid_outputs: got ack %b rd %h/%h want 00 0000/0000",
                           ack, rdata[0], rdata[1]);
      end
      n_vec++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 25'h0) begin
         n_err++; $display("FAIL mid_mem_if: got %b/%h/%h want 0/0000/00",
                           bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      n_vec++;
      if (mem[16'h0100] !== 8'hEF || mem[16'h0101] !== 8'h5A) begin
         n_err++; $display("FAIL mid_bytes: got %h,%h want ef,5a", mem[16'h0100], mem[16'h0101]);
      end
      @(posedge clk); #1 reset = 1'b0;
      ref_mem[16'h0100] = 8'hEF;
      model_last = 1'b1;
      exp_port[0] = 16'h0; exp_port[1] = 16'h0;
      wide = 2'b00;
   endtask

   task automatic test_random();
      logic [1:0] act;
      int bad;
      for (int it = 0; it < 40; it++) begin
         act = 2'($urandom_range(1, 3));
         for (int p = 0; p < 2; p++) begin
            we[p] = 1'($urandom);
            wide[p] = 1'($urandom);
            addr[p] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'(16'h0020 + $urandom_range(0, 15));
            wdata[p] = 16'($urandom);
         end
         model_pair(act); run_pair(act);
         n_vec++;
         if (nd !== exp_n) begin n_err++; $display("FAIL rnd_count: got %0d want %0d", nd, exp_n); end
         n_vec++;
         if (lat[0] !== exp_lat0) begin
            n_err++; $display("FAIL rnd_latency: got %0d want %0d", lat[0], exp_lat0);
         end
         for (int i = 0; i < exp_n; i++) begin
            n_vec++;
            if (ord[i] !== exp_ord[i] || got_rd[i] !== exp_rd[i]) begin
               n_err++; $display("FAIL rnd_xfer: got port %0d rd %h want port %0d rd %h",
                                 ord[i], got_rd[i], exp_ord[i], exp_rd[i]);
            end
         end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      bad = 0;
      for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) bad++;
      n_vec++;
      if (bad != 0) begin n_err++; $display("FAIL mem_contents: got %0d bad bytes want 0", bad); end
   endtask

   initial begin
      test_reset();
      test_narrow_p1();
      test_wide_wrap();
      test_contention();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer in front of `main_memory`. It shares the single-ported byte memory between the instruction-fetch port (port 0) and the load/store port (port 1). Each port can issue byte or 16-bit little-endian transfers; a 16-bit transfer is performed as two consecutive byte accesses. Ties between the two ports are resolved round-robin.

## Interface
Parameters:
- `word_size`, default 8: memory word width; must equal `main_memory.word_size`.
- `len_log_2`, default 16: address width.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `p0_req` / `p1_req`  in  1  transfer request; held high until ack.
- `p0_we` / `p1_we`  in  1  1 = write, 0 = read.
- `p0_wide` / `p1_wide`  in  1  1 = 16-bit transfer, 0 = 8-bit.
- `p0_addr` / `p1_addr`  in  `len_log_2`  byte address.
- `p0_wdata` / `p1_wdata`  in  `2*word_size`  write data; the low byte is used for narrow transfers.
- `p0_rdata` / `p1_rdata`  out  `2*word_size`  read data, registered; valid in the ack cycle.
- `p0_ack` / `p1_ack`  out  1  one-cycle completion pulse.
- `mem_addr`  out  `len_log_2`  to `main_memory.addr`.
- `mem_wdata`  out  `word_size`  to `main_memory.data_in`.
- `mem_we`  out  1  to `main_memory.write_enable`.
- `mem_rdata`  in  `word_size`  from `main_memory.data_out` (combinational read).

## Operation
- FSM states: IDLE, XFER_LO, XFER_HI.
- IDLE, arbitration:
  - Eligible requesters are those with `req` high, excluding any port whose ack is high this cycle.
  - If exactly one is eligible, it is granted.
  - If both are eligible, grant the port that is not `last_grant`.
  - On a grant: latch the winner's id, we, wide, addr and wdata into internal registers, set `last_grant`, and go to XFER_LO.
- XFER_LO:
  - `mem_addr` = latched addr; `mem_wdata` = wdata[7:0]; `mem_we` = latched we.
  - On a read, capture `mem_rdata` into rdata[7:0] at the clock edge.
  - If wide, go to XFER_HI. Otherwise go to IDLE, pulse ack for the granted port and update that port's rdata.
- XFER_HI:
  - `mem_addr` = latched addr + 1, modulo 2^`len_log_2` (so 0xFFFF wraps to 0x0000).
  - `mem_wdata` = wdata[15:8].
  - On a read, capture rdata[15:8].
  - Always go to IDLE and pulse ack.
- Narrow read: rdata[15:8] = 0.
- Write ack: rdata is unchanged.
- In IDLE: `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- `mem_we` is gated combinationally with `~reset`, so no write can commit on a reset edge.
- No range check against memory depth. Addresses ≥ len are the requester's responsibility.
- Requester rule: hold all fields stable from `req` rise until ack. Deassert `req` in the ack cycle, or keep it high to request again; the re-request is arbitrated one cycle after ack.

## Timing
- Reset values:
  - state = IDLE; `last_grant` = 1, so port 0 wins the first tie.
  - `p0_ack` = `p1_ack` = 0; `p0_rdata` = `p1_rdata` = 0.
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Narrow transfer: `req` sampled in IDLE at edge N; memory is accessed in cycle N+1; ack and rdata are valid in cycle N+2. Latency is 2 cycles.
- Wide transfer: ack in cycle N+3. Latency is 3 cycles.
- The other port can be granted in the ack cycle. Back-to-back transfers from the same port alternate with a 1-cycle bubble.
- Sustained contention alternates grants strictly; neither port waits more than one transfer.
- Reset mid-transfer aborts the transfer: no ack; a partial wide write may leave only the low byte written; the FSM returns to IDLE on the next edge.

## Structure
- Package `mem_arb_pkg`:
  - state encoding (IDLE/XFER_LO/XFER_HI);
  - port ids `PORT_FETCH` = 0, `PORT_DATA` = 1;
  - `NUM_PORTS` = 2.
- Sub-module `rr_arb2`: combinational two-input round-robin picker. Inputs are the two masked requests and `last_grant`; outputs are `grant_valid` and `grant_id`. `last_grant` itself stays in the parent.
- The top module holds the FSM, latch registers, the address incrementer and the per-port rdata/ack registers.

## Test plan
- Narrow write then read, port 1 only: write addr 0x0010 with 0xA5 → `mem_we` high for exactly 1 cycle, ack at N+2. Then read 0x0010 → `p1_rdata` = 0x00A5 at N+2.
- Wide write/read at the wrap boundary, port 0: write addr 0xFFFF with 0x1234 → byte 0xFFFF = 0x34, byte 0x0000 = 0x12. A wide read of the same address returns 0x1234, with ack at N+3.
- Simultaneous requests after reset, both narrow reads → port 0 acked first, port 1 granted in port 0's ack cycle. With both held high continuously, grants alternate 0,1,0,1.
- Same port re-requests in its ack cycle while the other port is idle → next grant one cycle after ack; `mem_we` stays 0 in the bubble.
- Reset asserted during XFER_HI of a wide write of 0xBEEF to 0x0100 → no ack; byte 0x0100 = 0xEF, byte 0x0101 unchanged; all outputs at reset values on the next cycle.
